// File: rtl/asteroid_field_if.sv
// Player-facing bus of the asteroid playfield: game control and tick in,
// grid and event flags out.
interface asteroid_field_if #(
    parameter int LANES = 4,
    parameter int ROWS  = 8
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  GameEnable;
    logic                  TickPulse;
    logic [LW-1:0]         PlayerLane;
    logic [LANES*ROWS-1:0] Field;
    logic                  Collision;
    logic                  DodgePulse;
    logic                  GameOver;

    modport master (
        output GameEnable, TickPulse, PlayerLane,
        input  Field, Collision, DodgePulse, GameOver
    );

    modport slave (
        input  GameEnable, TickPulse, PlayerLane,
        output Field, Collision, DodgePulse, GameOver
    );
endinterface

// File: rtl/asteroid_field.sv
// Scrolling asteroid grid with LFSR spawning and bottom-row collision
// detection against the player lane.
module asteroid_field #(
    parameter int         LANES = 4,
    parameter int         ROWS  = 8,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic              Clk,
    input  logic              Rst,
    asteroid_field_if.slave   bus
);
    localparam int         LW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int         FW       = LANES * ROWS;
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t          state_r;
    logic [FW-1:0]   field_r;
    logic [7:0]      lfsr_r;
    logic            collision_r;
    logic            dodge_r;
    logic            game_over_r;

    logic [LANES-1:0] bottom_s;
    logic [LANES-1:0] spawn_s;
    logic [7:0]       lfsr_next_s;
    logic             hit_s;

    // Hit detection on the registered grid and next-row spawn from the advanced LFSR
    always_comb begin
        bottom_s    = field_r[FW-1 -: LANES];
        hit_s       = bottom_s[bus.PlayerLane];
        lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        spawn_s     = '0;
        if (lfsr_next_s[7:6] != 2'b00) begin
            spawn_s[lfsr_next_s[LW-1:0]] = 1'b1;
        end else begin
            spawn_s = '0;
        end
    end

    // Game FSM; abort beats hit, and hit beats a same-cycle tick
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= IDLE;
            field_r     <= '0;
            lfsr_r      <= SEED_EFF;
            collision_r <= 1'b0;
            dodge_r     <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            collision_r <= 1'b0;
            dodge_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.GameEnable) begin
                        state_r <= RUN;
                        field_r <= '0;
                        lfsr_r  <= SEED_EFF;
                    end
                end
                RUN: begin
                    if (!bus.GameEnable) begin
                        state_r <= IDLE;
                        field_r <= '0;
                    end else if (hit_s) begin
                        state_r     <= OVER;
                        collision_r <= 1'b1;
                        game_over_r <= 1'b1;
                    end else if (bus.TickPulse) begin
                        lfsr_r  <= lfsr_next_s;
                        field_r <= {field_r[FW-LANES-1:0], spawn_s};
                        dodge_r <= |bottom_s;
                    end
                end
                OVER: begin
                    // Grid is frozen here so the display can show the crash
                    if (!bus.GameEnable) begin
                        state_r     <= IDLE;
                        game_over_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    field_r     <= '0;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Field      = field_r;
    assign bus.Collision  = collision_r;
    assign bus.DodgePulse = dodge_r;
    assign bus.GameOver   = game_over_r;
endmodule

// File: tb/tb_asteroid_field.sv
// Directed bench for asteroid_field: spawn, collision, dodge, lane-move hit,
// abort and mid-game reset, with hand-computed grid values.
module tb_asteroid_field;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] spawn_exp [8];

    asteroid_field_if #(.LANES(4), .ROWS(8)) bus ();

    asteroid_field #(.LANES(4), .ROWS(8), .SEED(8'hA5)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic tick();
        bus.TickPulse = 1'b1;
        @(negedge clk);
        bus.TickPulse = 1'b0;
    endtask

    task automatic pulses_zero(input string tag);
        check({tag, "_col"},   {31'd0, bus.Collision},  32'd0);
        check({tag, "_dodge"}, {31'd0, bus.DodgePulse}, 32'd0);
    endtask

    task automatic restart();
        bus.GameEnable = 1'b0;
        @(negedge clk);
        bus.GameEnable = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        spawn_exp[0] = 32'h00000004;
        spawn_exp[1] = 32'h00000042;
        spawn_exp[2] = 32'h00000420;
        spawn_exp[3] = 32'h00004201;
        spawn_exp[4] = 32'h00042012;
        spawn_exp[5] = 32'h00420128;
        spawn_exp[6] = 32'h04201288;
        spawn_exp[7] = 32'h42012884;

        rst            = 1'b1;
        bus.GameEnable = 1'b0;
        bus.TickPulse  = 1'b0;
        bus.PlayerLane = 2'd0;

        // Reset and start
        idle(2);
        check("rst_field", bus.Field, 32'h0);
        check("rst_over", {31'd0, bus.GameOver}, 32'd0);
        pulses_zero("rst");
        rst            = 1'b0;
        bus.GameEnable = 1'b1;
        @(negedge clk);
        check("start_field", bus.Field, 32'h0);
        pulses_zero("start");

        // Spawn sequence, lane 0, ticks spaced 10 cycles
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("spawn_t%0d", t + 1), bus.Field, spawn_exp[t]);
            pulses_zero($sformatf("spawn_t%0d", t + 1));
            idle(9);
            check($sformatf("hold_t%0d", t + 1), bus.Field, spawn_exp[t]);
        end

        // Dodge: lane-2 asteroid leaves bottom row with player in lane 0
        tick();
        check("dodge_field", bus.Field, 32'h20128842);
        check("dodge_pulse", {31'd0, bus.DodgePulse}, 32'd1);
        check("dodge_col", {31'd0, bus.Collision}, 32'd0);
        @(negedge clk);
        check("dodge_once", {31'd0, bus.DodgePulse}, 32'd0);

        // Abort with a simultaneous tick
        bus.GameEnable = 1'b0;
        bus.TickPulse  = 1'b1;
        @(negedge clk);
        bus.TickPulse  = 1'b0;
        check("abort_field", bus.Field, 32'h0);
        pulses_zero("abort");
        tick();
        check("idle_tick_ignored", bus.Field, 32'h0);

        // Re-enable reloads the LFSR
        bus.GameEnable = 1'b1;
        @(negedge clk);
        tick();
        check("reload_t1", bus.Field, 32'h00000004);

        // Mid-run reset clears and restarts from seed
        rst = 1'b1;
        @(negedge clk);
        check("midrst_field", bus.Field, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        tick();
        check("midrst_t1", bus.Field, 32'h00000004);

        // Collision: player in lane 2 meets the first spawned asteroid
        restart();
        bus.PlayerLane = 2'd2;
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("col_t%0d", t + 1), bus.Field, spawn_exp[t]);
        end
        check("col_bit30", {31'd0, bus.Field[30]}, 32'd1);
        check("col_not_yet", {31'd0, bus.Collision}, 32'd0);
        @(negedge clk);
        check("col_pulse", {31'd0, bus.Collision}, 32'd1);
        check("col_over", {31'd0, bus.GameOver}, 32'd1);
        check("col_nododge", {31'd0, bus.DodgePulse}, 32'd0);
        @(negedge clk);
        check("col_once", {31'd0, bus.Collision}, 32'd0);
        check("over_hold", {31'd0, bus.GameOver}, 32'd1);
        tick();
        tick();
        check("over_frozen", bus.Field, 32'h42012884);
        pulses_zero("over_tick");
        check("over_still", {31'd0, bus.GameOver}, 32'd1);
        bus.GameEnable = 1'b0;
        @(negedge clk);
        check("over_exit", {31'd0, bus.GameOver}, 32'd0);
        pulses_zero("over_exit");

        // Player steps into the asteroid while a tick arrives
        bus.PlayerLane = 2'd0;
        restart();
        for (int t = 0; t < 8; t++) tick();
        check("move_pre", bus.Field, 32'h42012884);
        check("move_pre_col", {31'd0, bus.Collision}, 32'd0);
        bus.PlayerLane = 2'd2;
        bus.TickPulse  = 1'b1;
        @(negedge clk);
        bus.TickPulse  = 1'b0;
        check("move_col", {31'd0, bus.Collision}, 32'd1);
        check("move_noscroll", bus.Field, 32'h42012884);
        check("move_nododge", {31'd0, bus.DodgePulse}, 32'd0);
        check("move_over", {31'd0, bus.GameOver}, 32'd1);
        @(negedge clk);
        check("move_once", {31'd0, bus.Collision}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/asteroid_field.md
Name: asteroid_field

Overview:
- Playfield engine that consumes the 100 ms-multiple timeout pulse from the variable-speed timer.
- On each tick: scrolls a LANES x ROWS asteroid grid down one row and spawns a new top row from an 8-bit LFSR.
- Checks the bottom (player) row against the player lane every cycle.
- Emits collision, dodge-score pulses and a game-over level to the game controller and display driver.

Parameters:
- LANES, 4, number of horizontal lanes. Power of two, 2..8.
- ROWS, 8, number of rows. Row 0 is the top row; row ROWS-1 is the player row.
- SEED, 8'hA5, LFSR load value on entry to RUN. 8'h00 is replaced by 8'h01.

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous reset, active-high
- GameEnable  in  1  level; high = game running
- TickPulse  in  1  one-cycle scroll request (timeout pulse of the variable timer)
- PlayerLane  in  log2(LANES)  current player lane
- Field  out  LANES*ROWS  grid; bit index r*LANES+l = asteroid at row r, lane l
- Collision  out  1  one-cycle pulse on hit
- DodgePulse  out  1  one-cycle pulse when an asteroid leaves the bottom row without a hit
- GameOver  out  1  level, high in state OVER

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - State=IDLE, Field=0, LFSR=SEED, Collision=0, DodgePulse=0.
  - Rst dominates all other inputs, including mid-game.
- FSM states: IDLE, RUN, OVER.
  - IDLE -> RUN when GameEnable=1. Same edge: Field<=0, LFSR<=SEED.
  - RUN -> IDLE when GameEnable=0. Same edge: Field<=0. This has priority over tick and collision.
  - RUN -> OVER when hit=1, where hit = Field[(ROWS-1)*LANES+PlayerLane] evaluated on registered Field and the current PlayerLane.
  - OVER -> IDLE when GameEnable=0. Field is held unchanged in OVER for display.
- TickPulse is ignored in IDLE and OVER. The LFSR advances only on accepted ticks.
- LFSR:
  - Feedback fb = L[7]^L[5]^L[4]^L[3].
  - Next value Ln = {L[6:0], fb}. L<=Ln on each accepted tick.
- Scroll, on a tick in RUN with hit=0:
  - Row r <= row r-1 for r = 1..ROWS-1.
  - Row 0 <= one-hot(Ln[log2(LANES)-1:0]) if Ln[7:6] != 2'b00, else 0.
  - The old bottom row is discarded. If it was nonzero, DodgePulse=1 on the next cycle.
- Latency:
  - Field updates on the edge after the sampled TickPulse (visible 1 cycle later).
  - Collision and GameOver rise on the edge after hit is first seen, i.e. 1 cycle after the Field or PlayerLane change that caused it.
- Collision pulses exactly once per game. GameOver holds until the FSM leaves OVER.
- Simultaneous tick and hit: the hit wins. No scroll, no LFSR advance, no DodgePulse.
- Moving PlayerLane into an occupied bottom-row lane is a hit, even without a tick.
- A scroll that places an asteroid under the player is detected the following cycle, not on the scrolling edge.
- Collision and DodgePulse are 0 in every cycle not listed above. They are never both 1 in the same cycle.
- All arithmetic is unsigned. No counters wrap; the grid itself is the only storage besides the LFSR and FSM.

Test Plan:
1. Reset and start: Rst=1 for 2 cycles, then GameEnable=1. Required: Field=0, GameOver=0, no pulses, state RUN one cycle after GameEnable rises.
2. Spawn sequence, defaults, PlayerLane=0, three ticks 10 cycles apart. Required Field after each tick: 32'h00000004, then 32'h00000042, then 32'h00000420 (LFSR 4A, 95, 2A).
3. Collision, PlayerLane=2, 8 ticks. Required:
   - After tick 8, Field bit 30 = 1.
   - Collision pulses one cycle later and GameOver=1.
   - Extra ticks leave Field unchanged.
   - GameEnable=0 then returns to IDLE with GameOver=0.
4. Dodge, PlayerLane=0, 9 ticks. Required: on tick 9, the lane-2 asteroid leaves row 7, DodgePulse=1 for exactly one cycle, Collision=0.
5. Player moves into asteroid: after 8 ticks with PlayerLane=0 (bit 30 set), switch PlayerLane to 2 with no tick. Required: Collision one cycle later; a TickPulse in the same cycle as hit does not scroll.
6. Mid-game abort: GameEnable=0 in the same cycle as TickPulse. Required: IDLE, Field=0. Re-enable plus the first tick gives Field=32'h00000004 (LFSR reloaded). Rst=1 mid-RUN has the same clearing effect.
